mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequencer for one `mac_acc` instance in the MNIST inference datapath. On `start` it walks every output neuron:
- fetches `WPN` 128-bit pixel words and `WPN` 128-bit weight words from synchronous-read memories;
- drives the MAC's clear and data-valid strobes;
- waits out the MAC latency, then presents each 22-bit accumulated score on a valid/ready result port.

It sits between the image/weight ROMs, the MAC, and the argmax/classifier stage.

## Interface
Parameters:
- `WPN`, 4: 128-bit words per neuron (16 pixels of 8 bits per word).
- `NUM_NEURONS`, 10: neurons per image.
- `ADDR_W`, 8: memory address width.
- `OUT_W`, 22: accumulator/result width.
- `MAC_LAT`, 2: cycles from the last `mac_en` to a valid `acc_in`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin one image. Sampled only in IDLE.
- `img_base`, in, `ADDR_W`: pixel-memory base address of the image. Latched at start.
- `busy`, out, 1: high from the cycle after start is accepted through the done pulse.
- `done`, out, 1: one-cycle pulse after the last result handshake.
- `mem_en`, out, 1: read enable for both memories.
- `pix_addr`, out, `ADDR_W`: equals `img_base + k`.
- `w_addr`, out, `ADDR_W`: equals `n*WPN + k`.
- `mac_clr`, out, 1: clear-and-load strobe to the MAC, coincident with the first `mac_en` of each neuron.
- `mac_en`, out, 1: the memory data on p/w this cycle is valid for the MAC.
- `acc_in`, in, `OUT_W`: MAC accumulator output.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts the result.
- `res_data`, out, `OUT_W`: captured score.
- `res_idx`, out, 4: neuron index n of `res_data`.

## Operation
- Counters: `k` is the word index (0..WPN-1). `n` is the neuron index (0..NUM_NEURONS-1). `w` counts the WAIT cycles.
- FSM states: IDLE, ISSUE, WAIT, OUT, DONE.
  - IDLE: when `start`=1, latch `img_base`, set n=0 and k=0, go to ISSUE.
  - ISSUE: `mem_en`=1 with the addresses above; k increments each cycle. After the k=WPN-1 cycle, go to WAIT and clear w.
  - WAIT: lasts exactly `MAC_LAT+1` cycles. On the last WAIT cycle, `res_data` samples `acc_in` and `res_idx` takes n. Then go to OUT.
  - OUT: `res_valid`=1 while `res_data` and `res_idx` are held stable. On `res_valid & res_ready`:
    - if n==NUM_NEURONS-1, go to DONE;
    - otherwise n increments, k is set to 0, and the FSM goes to ISSUE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `mac_en` is `mem_en` delayed one cycle, to match the 1-cycle memory read latency.
- `mac_clr` is high only on the `mac_en` cycle that corresponds to k=0.
- Arithmetic:
  - `w_addr` is computed with an incrementing register (+1 per issued word, not reset between neurons), not a multiplier.
  - `pix_addr` wraps modulo 2^ADDR_W.
- `start` is ignored when not in IDLE, including in DONE.
- Reset, including mid-operation: every output is 0 and the FSM enters IDLE immediately.
  - An in-flight result is discarded.
  - The MAC is re-cleared by the next `mac_clr`.

## Timing
- Reset values: `busy`, `done`, `mem_en`, `mac_en`, `mac_clr`, `res_valid` = 0. `pix_addr`, `w_addr`, `res_data`, `res_idx` = 0.
- Cycle numbering: the start is accepted at edge E0, and cycle c1 is the first cycle after E0.
  - `mem_en` is high in c1..c4.
  - `mac_en` is high in c2..c5, with `mac_clr` in c2.
  - WAIT occupies c5..c7.
  - `res_valid` rises in c8. General formula: `WPN+MAC_LAT+2` cycles after E0.
- Per-neuron period with `res_ready` held high: `WPN+MAC_LAT+2` = 8 cycles.
  - The next ISSUE begins the cycle after the handshake.
- Full image with `res_ready` held high: `done` occurs in cycle `NUM_NEURONS*8+1` = c81. `busy` falls in c82.
- Backpressure: each extra cycle `res_ready` is low delays all later events by one cycle. No results are dropped or duplicated.

## Test plan
- Reset check: hold `rst_n`=0 and toggle `start` -> all outputs stay 0 and the FSM stays IDLE. Release reset -> the first `start` is accepted.
- Single image with `img_base`=0x10 and `res_ready`=1:
  - `pix_addr` cycles 0x10..0x13 for each neuron;
  - `w_addr` runs 0..39 continuously;
  - `mac_clr` is high exactly 10 times;
  - `res_valid` is first high in c8;
  - `res_idx` runs 0..9;
  - `done` occurs in c81.
- Result capture: a MAC model returns `acc_in` = 0x3A000+n on the last WAIT cycle -> each `res_data` equals 0x3A000+`res_idx`.
- Backpressure: hold `res_ready`=0 for 5 cycles on neuron 3 -> `res_data` and `res_idx` stay stable, no new ISSUE starts, and `done` moves to c86.
- Ignored start: pulse `start` during ISSUE, OUT and DONE -> no restart and addresses are unaffected. A `start` in the cycle after DONE is accepted.
- Mid-run reset: assert `rst_n`=0 in WAIT of neuron 5 -> all outputs are 0 within the same cycle. A new start then re-runs from n=0 with `w_addr` starting at 0.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one mac_acc instance: fetches pixel/weight words per neuron,
// strobes the MAC, and hands each accumulated score out on a valid/ready port.
module mac_seq_ctrl #(
    parameter int WPN         = 4,
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 8,
    parameter int OUT_W       = 22,
    parameter int MAC_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_base,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              mac_clr,
    output logic              mac_en,
    input  logic [OUT_W-1:0]  acc_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic [3:0]        res_idx
);

    localparam int KW = (WPN > 1) ? $clog2(WPN) : 1;
    localparam int LW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [KW-1:0]     k;
    logic [3:0]        n;
    logic [LW-1:0]     w;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] w_cnt;
    logic              last_k;
    logic              last_w;
    logic              last_n;

    assign last_k   = (k == KW'(WPN - 1));
    assign last_w   = (w == LW'(MAC_LAT));
    assign last_n   = (n == 4'(NUM_NEURONS - 1));
    assign pix_addr = base_q + ADDR_W'(k);
    assign w_addr   = w_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_en    = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en = 1'b1;
                if (last_k) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (last_w) begin
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = last_n ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // Weight address is a free-running word counter across neurons, so
    // n*WPN+k comes out without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            n        <= '0;
            w        <= '0;
            base_q   <= '0;
            w_cnt    <= '0;
            res_data <= '0;
            res_idx  <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
        end else begin
            mac_en  <= mem_en;
            mac_clr <= mem_en && (k == '0);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= img_base;
                        k      <= '0;
                        n      <= '0;
                        w_cnt  <= '0;
                    end
                end
                S_ISSUE: begin
                    w_cnt <= w_cnt + 1'b1;
                    if (last_k) begin
                        k <= '0;
                        w <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_WAIT: begin
                    w <= w + 1'b1;
                    if (last_w) begin
                        res_data <= acc_in;
                        res_idx  <= n;
                    end
                end
                S_OUT: begin
                    if (res_ready && !last_n) begin
                        n <= n + 1'b1;
                        k <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: a per-neuron schedule model predicts
// every strobe, address and result cycle by cycle.
module tb_mac_seq_ctrl;

    localparam int WPN         = 4;
    localparam int NUM_NEURONS = 10;
    localparam int ADDR_W      = 8;
    localparam int OUT_W       = 22;
    localparam int MAC_LAT     = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] img_base;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [ADDR_W-1:0] pix_addr;
    logic [ADDR_W-1:0] w_addr;
    logic              mac_clr;
    logic              mac_en;
    logic [OUT_W-1:0]  acc_in;
    logic              res_valid;
    logic              res_ready;
    logic [OUT_W-1:0]  res_data;
    logic [3:0]        res_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mac_seq_ctrl #(
        .WPN        (WPN),
        .NUM_NEURONS(NUM_NEURONS),
        .ADDR_W     (ADDR_W),
        .OUT_W      (OUT_W),
        .MAC_LAT    (MAC_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .img_base (img_base),
        .busy     (busy),
        .done     (done),
        .mem_en   (mem_en),
        .pix_addr (pix_addr),
        .w_addr   (w_addr),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .acc_in   (acc_in),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_idx  (res_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string where);
        checkOutput({where, ".busy"},      32'(busy),      32'd0);
        checkOutput({where, ".done"},      32'(done),      32'd0);
        checkOutput({where, ".mem_en"},    32'(mem_en),    32'd0);
        checkOutput({where, ".mac_en"},    32'(mac_en),    32'd0);
        checkOutput({where, ".mac_clr"},   32'(mac_clr),   32'd0);
        checkOutput({where, ".res_valid"}, 32'(res_valid), 32'd0);
        checkOutput({where, ".pix_addr"},  32'(pix_addr),  32'd0);
        checkOutput({where, ".w_addr"},    32'(w_addr),    32'd0);
        checkOutput({where, ".res_data"},  32'(res_data),  32'd0);
        checkOutput({where, ".res_idx"},   32'(res_idx),   32'd0);
    endtask

    // One image. Called at a negedge with the DUT idle; returns at a negedge
    // with the DUT idle. mode 0: ready held high; mode 1: random ready, start
    // noise and random acc; mode 2: 5-cycle stall on neuron 3 plus start
    // pulses in ISSUE, OUT and DONE. rst_neuron >= 0 resets in its WAIT.
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int mode,
                                 input int rst_neuron, input int exp_done_c);
        int n, s, t, done_c, stall, clr_seen, obs_done_c;
        logic e_mem, e_mac, e_clr, e_valid, e_busy, e_done;
        logic [ADDR_W-1:0] pix_e;
        logic [OUT_W-1:0] exp_data;
        bit finished;
        n = 0; s = 1; done_c = -1; stall = 0; clr_seen = 0; obs_done_c = -1;
        exp_data = '0; finished = 0;
        start = 1'b1;
        img_base = base;
        res_ready = 1'b0;
        for (int c = 1; c < 2000; c++) begin
            @(negedge clk);
            cyc = c;
            t = c - s;
            e_mem = 0; e_mac = 0; e_clr = 0; e_valid = 0; e_busy = 1; e_done = 0;
            if (done_c < 0) begin
                e_mem   = (t < WPN);
                e_mac   = (t >= 1) && (t <= WPN);
                e_clr   = (t == 1);
                e_valid = (t >= WPN + MAC_LAT + 1);
            end else if (c == done_c) begin
                e_done = 1;
            end else begin
                e_busy = 0;
            end
            checkOutput("busy",      32'(busy),      32'(e_busy));
            checkOutput("done",      32'(done),      32'(e_done));
            checkOutput("mem_en",    32'(mem_en),    32'(e_mem));
            checkOutput("mac_en",    32'(mac_en),    32'(e_mac));
            checkOutput("mac_clr",   32'(mac_clr),   32'(e_clr));
            checkOutput("res_valid", 32'(res_valid), 32'(e_valid));
            if (e_mem) begin
                pix_e = base + ADDR_W'(t);
                checkOutput("pix_addr", 32'(pix_addr), 32'(pix_e));
                checkOutput("w_addr",   32'(w_addr),   32'(n * WPN + t));
            end
            if (e_valid) begin
                checkOutput("res_data", 32'(res_data), 32'(exp_data));
                checkOutput("res_idx",  32'(res_idx),  32'(n));
            end
            if (mac_clr) clr_seen++;
            if (done) obs_done_c = c;

            if (done_c < 0 && n == rst_neuron && t == WPN + 1) begin
                rst_n = 1'b0;
                #1;
                checkAllZero("midreset");
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk);
                    start = ~start;
                    checkAllZero("midreset_hold");
                end
                start = 1'b0;
                rst_n = 1'b1;
                finished = 1;
                break;
            end
            if (done_c >= 0 && c == done_c + 1) begin
                start = 1'b0;
                finished = 1;
                break;
            end

            acc_in = OUT_W'($urandom);
            if (done_c < 0 && t == WPN + MAC_LAT) begin
                if (mode != 1) acc_in = OUT_W'(22'h3A000 + n);
                exp_data = acc_in;
            end
            case (mode)
                1: begin
                    res_ready = ($urandom_range(0, 2) != 0);
                    start     = 1'($urandom_range(0, 1));
                    img_base  = ADDR_W'($urandom);
                end
                2: begin
                    if (e_valid && n == 3 && stall < 5) begin
                        res_ready = 1'b0;
                        stall++;
                    end else begin
                        res_ready = 1'b1;
                    end
                    start    = (done_c < 0 && (t == 2 || e_valid)) || (c == done_c);
                    img_base = ADDR_W'($urandom);
                end
                default: begin
                    res_ready = 1'b1;
                    start     = 1'b0;
                end
            endcase
            if (done_c < 0 && e_valid && res_ready) begin
                if (n == NUM_NEURONS - 1) begin
                    done_c = c + 1;
                end else begin
                    n++;
                    s = c + 1;
                end
            end
        end
        checkOutput("image_finished", 32'(finished), 32'd1);
        if (exp_done_c != 0) begin
            checkOutput("done_cycle",    32'(obs_done_c), 32'(exp_done_c));
            checkOutput("mac_clr_count", 32'(clr_seen),   32'(NUM_NEURONS));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        img_base  = '0;
        res_ready = 1'b0;
        acc_in    = '0;
        #1;
        checkAllZero("reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start    = ~start;
            img_base = ADDR_W'($urandom);
            checkAllZero("reset_hold");
        end
        @(negedge clk);
        checkAllZero("reset_hold");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("after_release");

        $display("[TB] directed image, base 0x10, ready held high");
        applyStimulus(8'h10, 0, -1, NUM_NEURONS * (WPN + MAC_LAT + 2) + 1);
        $display("[TB] backpressure on neuron 3 with ignored starts");
        applyStimulus(8'h20, 2, -1, NUM_NEURONS * (WPN + MAC_LAT + 2) + 1 + 5);
        $display("[TB] random image with pixel address wrap");
        applyStimulus(8'hFE, 1, -1, 0);
        $display("[TB] mid-run reset in WAIT of neuron 5");
        applyStimulus(ADDR_W'($urandom), 1, 5, 0);
        $display("[TB] restart after reset");
        applyStimulus(ADDR_W'($urandom), 0, -1, NUM_NEURONS * (WPN + MAC_LAT + 2) + 1);
        for (int i = 0; i < 3; i++) begin
            $display("[TB] random image %0d", i);
            applyStimulus(ADDR_W'($urandom), 1, -1, 0);
        end
        @(negedge clk);
        checkOutput("final_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
